// File: rtl/toggle_power_monitor_if.sv
// Control and result signals of the toggle power monitor; clock and reset stay
// outside the interface as plain ports.
interface toggle_power_monitor_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 24
);
    logic                      en;
    logic                      clr;
    logic [CHANNELS-1:0]       ch_mask;
    logic [CHANNELS*WIDTH-1:0] d;
    logic [CNT_W-1:0]          acc;
    logic [CNT_W-1:0]          win_cnt;
    logic                      win_valid;
    logic                      sat;
    logic                      busy;

    modport master (
        output en, clr, ch_mask, d,
        input  acc, win_cnt, win_valid, sat, busy
    );

    modport slave (
        input  en, clr, ch_mask, d,
        output acc, win_cnt, win_valid, sat, busy
    );
endinterface

// File: rtl/toggle_power_monitor.sv
// Weighted toggle counter over masked channels, totalled per fixed-length window
// with a saturating accumulator and a sticky saturation flag.
//
// state   | meaning
// IDLE    | monitor off, ACC and window position retained
// PRIME   | capture first reference sample, nothing counted
// COUNT   | accumulate weighted toggles, close window at WINDOW-1
module toggle_power_monitor #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int WEIGHT   = 1,
    parameter int CNT_W    = 24,
    parameter int WINDOW   = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    toggle_power_monitor_if.slave bus
);
    localparam int INC_W = $clog2(CHANNELS * WIDTH * WEIGHT + 1);
    localparam int ADD_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    localparam int WC_W  = $clog2(WINDOW);
    localparam logic [ADD_W-1:0] SUM_MAX = {{(ADD_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_COUNT
    } state_t;

    state_t                    r_state;
    logic [CHANNELS*WIDTH-1:0] r_prev;
    logic [CNT_W-1:0]          r_acc;
    logic [CNT_W-1:0]          r_win_cnt;
    logic [WC_W-1:0]           r_wcnt;
    logic                      r_win_valid;
    logic                      r_sat;
    logic                      r_busy;

    logic [CHANNELS*WIDTH-1:0] w_diff;
    logic [INC_W-1:0]          w_pop;
    logic [INC_W-1:0]          w_inc;
    logic [ADD_W-1:0]          w_sum;
    logic                      w_ovf;
    logic [CNT_W-1:0]          w_acc_next;
    logic                      w_close;

    assign w_diff = bus.d ^ r_prev;

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.ch_mask[k]) begin
                for (int b = 0; b < WIDTH; b++) begin
                    w_pop = w_pop + INC_W'(w_diff[k*WIDTH+b]);
                end
            end
        end
    end

    // INC_W is sized for the full weighted maximum, so the product never wraps
    assign w_inc      = w_pop * INC_W'(WEIGHT);
    assign w_sum      = ADD_W'(r_acc) + ADD_W'(w_inc);
    assign w_ovf      = (w_sum > SUM_MAX);
    assign w_acc_next = w_ovf ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    assign w_close    = (r_wcnt == WC_W'(WINDOW - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_prev      <= '0;
            r_acc       <= '0;
            r_win_cnt   <= '0;
            r_wcnt      <= '0;
            r_win_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_win_valid <= 1'b0;
            if (r_state != S_IDLE) begin
                r_prev <= bus.d;
            end

            if (bus.clr) begin
                r_acc   <= '0;
                r_wcnt  <= '0;
                r_sat   <= 1'b0;
                r_state <= bus.en ? S_PRIME : S_IDLE;
                r_busy  <= bus.en;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.en) begin
                            r_state <= S_PRIME;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_PRIME: begin
                        r_state <= S_COUNT;
                        r_busy  <= 1'b1;
                    end
                    S_COUNT: begin
                        if (w_ovf) begin
                            r_sat <= 1'b1;
                        end
                        if (w_close) begin
                            r_win_cnt   <= w_acc_next;
                            r_acc       <= '0;
                            r_wcnt      <= '0;
                            r_win_valid <= 1'b1;
                        end else begin
                            r_acc  <= w_acc_next;
                            r_wcnt <= r_wcnt + WC_W'(1);
                        end
                        // Window position survives a pause; only CLR/reset restarts it
                        if (!bus.en) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.acc       = r_acc;
    assign bus.win_cnt   = r_win_cnt;
    assign bus.win_valid = r_win_valid;
    assign bus.sat       = r_sat;
    assign bus.busy      = r_busy;
endmodule
